// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared scan states, blanking constants and hex-to-segment table
package seven_seg_pkg;
  typedef enum logic {ST_BLANK, ST_DRIVE} scan_state_t;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF = 4'b1111;
  // Active-low {g,f,e,d,c,b,a}, entry 0 in the least significant slot
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
endpackage

// File: rtl/seg_scan_ctrl_if.sv
// seg_scan_ctrl_if: value load handshake and display drive signals of the scan controller
interface seg_scan_ctrl_if;
  logic [15:0] value_i;
  logic [3:0] dp_i;
  logic blank_lz_i;
  logic load_i;
  logic pending_o;
  logic [3:0] anode_o;
  logic [6:0] seg_o;
  logic dp_o;
  logic frame_o;
  modport master (output value_i, dp_i, blank_lz_i, load_i, input pending_o, anode_o, seg_o, dp_o, frame_o);
  modport slave (input value_i, dp_i, blank_lz_i, load_i, output pending_o, anode_o, seg_o, dp_o, frame_o);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: hex nibble to active-low seven-segment pattern
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit common-anode scan with blank interval and frame-aligned double buffering
module seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGIT_TICKS = 50000,
  parameter int BLANK_TICKS = 500
) (
  input logic clk_i,
  input logic reset_i,
  seg_scan_ctrl_if.slave bus
);
  localparam int CW = (DIGIT_TICKS > 2) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK = CW'(BLANK_TICKS);
  scan_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0] digit, digit_n;
  logic [15:0] disp_val, pend_val;
  logic [3:0] disp_dp, pend_dp;
  logic pend, boundary, lz_blank;
  logic [3:0] nib;
  logic [6:0] seg_dec;
  always_comb begin
    boundary = digit == 2'd3 && cnt == LAST;
    cnt_n = cnt == LAST ? '0 : cnt + 1'b1;
    digit_n = cnt == LAST ? digit + 2'd1 : digit;
    state_n = cnt_n < BLANK ? ST_BLANK : ST_DRIVE;
    nib = disp_val[{digit, 2'b00} +: 4];
    lz_blank = bus.blank_lz_i && digit != 2'd0 && (disp_val >> {digit, 2'b00}) == 16'd0;
  end
  hex_to_seg7 u_dec (.nibble(nib), .seg(seg_dec));
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= ST_BLANK;
      cnt <= '0;
      digit <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      digit <= digit_n;
    end
  end
  // A load on the boundary cycle bypasses the pending buffer
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      disp_val <= '0;
      disp_dp <= '0;
      pend_val <= '0;
      pend_dp <= '0;
      pend <= 1'b0;
    end else if (boundary) begin
      disp_val <= bus.load_i ? bus.value_i : pend ? pend_val : disp_val;
      disp_dp <= bus.load_i ? bus.dp_i : pend ? pend_dp : disp_dp;
      pend <= 1'b0;
    end else if (bus.load_i) begin
      pend_val <= bus.value_i;
      pend_dp <= bus.dp_i;
      pend <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus.anode_o <= AN_OFF;
      bus.seg_o <= SEG_OFF;
      bus.dp_o <= 1'b1;
      bus.frame_o <= 1'b0;
    end else begin
      bus.anode_o <= state == ST_DRIVE ? ~(4'b0001 << digit) : AN_OFF;
      bus.seg_o <= state == ST_DRIVE && !lz_blank ? seg_dec : SEG_OFF;
      bus.dp_o <= state == ST_DRIVE ? ~disp_dp[digit] : 1'b1;
      bus.frame_o <= boundary;
    end
  end
  assign bus.pending_o = pend;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed plan plus random loads/resets checked against a time-based scan model
module tb_seg_scan_ctrl;
  localparam int DT = 8;
  localparam int BT = 2;
  localparam int FRAME = 4 * DT;
  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int errors = 0;
  int checks = 0;
  int p = 0;
  logic cur_lz = 1'b0;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_ddp, m_pdp;
  bit m_pf;
  logic [3:0] e_anode;
  logic [6:0] e_seg;
  logic e_dp, e_frame, e_pend;
  logic [6:0] ref_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  seg_scan_ctrl_if bus ();
  seg_scan_ctrl #(.DIGIT_TICKS(DT), .BLANK_TICKS(BT)) dut (.clk_i(clk_i), .reset_i(reset_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h cycle=%0d", tag, got, exp, p);
    end
  endtask
  // Expected outputs after an edge follow from where cycle p sits in the frame
  task automatic model_edge(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz, input logic rst);
    int slot, ph;
    bit drive, blanked, bnd;
    logic [3:0] one_low;
    if (rst) begin
      e_anode = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_frame = 1'b0; e_pend = 1'b0;
      m_disp = '0; m_ddp = '0; m_pend = '0; m_pdp = '0; m_pf = 1'b0; p = 0;
      return;
    end
    slot = (p / DT) % 4;
    ph = p % DT;
    drive = ph >= BT;
    blanked = lz && slot != 0 && ((m_disp >> (4 * slot)) == 16'd0);
    one_low = 4'b0001 << slot;
    e_anode = drive ? ~one_low : 4'hF;
    e_seg = (drive && !blanked) ? ref_tab[(m_disp >> (4 * slot)) & 16'hF] : 7'h7F;
    e_dp = drive ? ~m_ddp[slot] : 1'b1;
    bnd = (p % FRAME) == FRAME - 1;
    e_frame = bnd;
    if (bnd) begin
      if (ld) begin m_disp = v; m_ddp = d; end
      else if (m_pf) begin m_disp = m_pend; m_ddp = m_pdp; end
      m_pf = 1'b0;
    end else if (ld) begin
      m_pend = v; m_pdp = d; m_pf = 1'b1;
    end
    e_pend = m_pf;
    p++;
  endtask
  task automatic cycle(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic lz, input logic rst);
    bus.load_i = ld; bus.value_i = v; bus.dp_i = d; bus.blank_lz_i = lz; reset_i = rst;
    @(posedge clk_i);
    model_edge(ld, v, d, lz, rst);
    #1;
    check("anode", 16'(bus.anode_o), 16'(e_anode));
    check("seg", 16'(bus.seg_o), 16'(e_seg));
    check("dp", 16'(bus.dp_o), 16'(e_dp));
    check("frame", 16'(bus.frame_o), 16'(e_frame));
    check("pending", 16'(bus.pending_o), 16'(e_pend));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 16'($urandom), 4'($urandom), cur_lz, 1'b0);
  endtask
  task automatic run_until(input int ph);
    for (int i = 0; i < FRAME && (p % FRAME) != ph; i++) idle(1);
  endtask
  task automatic load(input logic [15:0] v, input logic [3:0] d);
    cycle(1'b1, v, d, cur_lz, 1'b0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 4'h0, 1'b0, 1'b1);
    idle(40);
    run_until(5);
    load(16'h12AF, 4'b0100);
    idle(2 * FRAME);
    run_until(3);
    load(16'h1111, 4'h0);
    idle(7);
    load(16'h2222, 4'h0);
    idle(2 * FRAME);
    run_until(FRAME - 1);
    load(16'h0008, 4'h0);
    idle(FRAME + 4);
    cur_lz = 1'b1;
    idle(FRAME);
    run_until(FRAME - 1);
    load(16'h0000, 4'h3);
    idle(FRAME + 2);
    cur_lz = 1'b0;
    run_until(2 * DT + 2);
    load(16'h4321, 4'hF);
    idle(2);
    cycle(1'b0, 16'h0, 4'h0, cur_lz, 1'b1);
    idle(2 * FRAME);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 63) == 0) cur_lz = 1'($urandom);
      if ($urandom_range(0, 599) == 0) cycle(1'b0, 16'h0, 4'h0, cur_lz, 1'b1);
      else cycle(1'($urandom_range(0, 15) == 0), 16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                 4'($urandom), cur_lz, 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display.
- Sequences digit selection with a programmable slot period and an anti-ghosting blank interval.
- Double-buffers the displayed 16-bit value, applying updates only at frame boundaries so no frame shows mixed digits.
- Decodes hex nibbles to active-low segments, with optional leading-zero blanking.

Parameters:
DIGIT_TICKS, 50000, clock cycles per digit slot (blank plus drive); legal range 2..2^20.
BLANK_TICKS, 500, cycles at the start of each slot with all anodes off; legal range 1..DIGIT_TICKS-1.

Ports:
clk_i  input  1  system clock; single clock domain.
reset_i  input  1  synchronous, active-high reset.
value_i  input  16  value to display; digit d = value_i[4d+3:4d]; digit 0 is rightmost.
dp_i  input  4  decimal point request per digit, active high; sampled with value_i.
blank_lz_i  input  1  leading-zero blanking enable; used live, not buffered.
load_i  input  1  single-cycle strobe that captures value_i/dp_i.
pending_o  output  1  high while a captured value is waiting for the next frame boundary.
anode_o  output  4  digit enables, active low; anode_o[0] = digit 0.
seg_o  output  7  segments {g,f,e,d,c,b,a}, active low.
dp_o  output  1  decimal point, active low.
frame_o  output  1  one-cycle pulse on the last cycle of digit 3's slot.

Behaviour:
- Reset: internal state
  - state = ST_BLANK, digit = 0, tick counter = 0.
  - display and pending registers = 0, pending flag = 0.
- Reset: outputs
  - anode_o = 4'b1111, seg_o = 7'b1111111, dp_o = 1.
  - frame_o = 0, pending_o = 0.
- Reset mid-frame aborts the slot, discards any pending value, and returns to the reset values on the next edge.
- Tick counter runs 0..DIGIT_TICKS-1, then wraps to 0 and advances digit 0->1->2->3->0.
- FSM has two states:
  - ST_BLANK while counter < BLANK_TICKS.
  - ST_DRIVE for the remaining DIGIT_TICKS-BLANK_TICKS cycles.
- Outputs are registered, one cycle behind the state/counter.
- In ST_BLANK: anode_o = 1111, seg_o = 1111111, dp_o = 1.
- In ST_DRIVE:
  - anode_o has only bit[digit] low.
  - seg_o = decode(display nibble); dp_o = ~display_dp[digit].
- Frame period is 4*DIGIT_TICKS cycles. Each anode is low for exactly DIGIT_TICKS-BLANK_TICKS consecutive cycles per frame.
- Two anode bits are never low in the same cycle.
- Frame boundary is the cycle where digit = 3 and counter = DIGIT_TICKS-1. frame_o pulses high the following cycle (registered).
- Load handshake:
  - load_i high copies value_i/dp_i into the pending registers and sets the pending flag.
  - A second load before the boundary overwrites the pending value; last load wins.
  - At the frame boundary, if pending is set, pending copies to display and pending clears.
  - load_i coincident with the boundary cycle writes value_i/dp_i directly to display; pending clears.
  - pending_o is the registered pending flag.
- Leading-zero blanking: with blank_lz_i = 1, digit d (d = 3..1) is forced to seg_o = 1111111 when its nibble and all higher nibbles are 0.
  - Digit 0 is never blanked.
  - dp_o still follows dp_i on blanked digits.
- Decode is hex 0-F. Examples:
  - 0 = 1000000, 1 = 1111001, 8 = 0000000.
  - A = 0001000, F = 0001110.

Decomposition:
- Package seven_seg_pkg holds:
  - the scan_state_t enum {ST_BLANK, ST_DRIVE}.
  - constants SEG_OFF = 7'b1111111 and AN_OFF = 4'b1111.
  - the 16-entry hex-to-segment constant table.
- One combinational sub-module, hex_to_seg7 (nibble in, 7-bit active-low segments out), instantiated once on the selected digit.

Test Plan (DIGIT_TICKS=8, BLANK_TICKS=2):
1. Reset held for 3 cycles, then released -> outputs stay at reset values for 3 cycles, then anode_o = 1110 for 6 cycles; frame_o first pulses at cycle 32.
2. load_i with value_i = 16'h12AF, dp_i = 0100 -> pending_o = 1 until the next frame boundary. The following frame drives:
   - digit 0 seg = 0001110.
   - digit 1 seg = 0001000.
   - digit 2 seg = 0100100 with dp_o = 0.
   - digit 3 seg = 1111001.
3. Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is ever displayed; pending_o clears at the boundary.
4. load_i exactly on the boundary cycle with 16'h0008 -> displayed from digit 0 of the next frame; pending_o never rises.
5. blank_lz_i = 1 with 16'h0008 -> digits 3..1 show seg 1111111, digit 0 shows 0000000. With 16'h0000, digit 0 shows 1000000.
6. reset_i asserted in the middle of digit 2's drive phase with a load pending -> next cycle returns to reset values, pending_o = 0, and the scan restarts at digit 0.
